// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: shared state and opcode definitions for the stack arbiter
package stack_arb_pkg;
    typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;
endpackage

// File: rtl/stack_rr_picker.sv
// stack_rr_picker: combinational round-robin pick of the first eligible client at or after start
module stack_rr_picker #(
    parameter int N = 4,
    localparam int W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] start,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[(int'(start) + i) % N]) begin
                gnt = '0;
                gnt[(int'(start) + i) % N] = 1'b1;
                idx = W'((int'(start) + i) % N);
            end
        end
    end
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one LIFO between clients, with lockable atomic sequences
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NCLI    = 4,
    parameter int DATA_W  = 4,
    parameter int LOCK_TO = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NCLI-1:0]          i_req,
    input  logic [NCLI-1:0]          i_op,
    input  logic [NCLI-1:0]          i_lock,
    input  logic [NCLI*DATA_W-1:0]   i_wdata,
    output logic [NCLI-1:0]          o_gnt,
    output logic [NCLI-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]        o_rsp_data,
    output logic                     o_locked,
    output logic                     o_stk_push,
    output logic                     o_stk_pop,
    output logic [DATA_W-1:0]        o_stk_data,
    input  logic [DATA_W-1:0]        i_stk_data,
    input  logic                     i_stk_full,
    input  logic                     i_stk_empty
);
    localparam int PW = $clog2(NCLI);
    localparam int CW = LOCK_TO > 0 ? $clog2(LOCK_TO + 1) : 1;

    arb_state_t      state;
    logic [PW-1:0]   rr, owner, w, w_nxt, own_nxt;
    logic [CW-1:0]   cnt;
    logic [NCLI-1:0] elig, pgnt;
    logic            any;

    always_comb begin
        elig = i_req & ((i_op & {NCLI{!i_stk_empty}}) | (~i_op & {NCLI{!i_stk_full}}));
        elig = state == ST_LOCKED ? elig & (NCLI'(1) << owner) : elig;
    end

    stack_rr_picker #(.N(NCLI)) u_pick (
        .elig  (elig),
        .start (state == ST_LOCKED ? owner : rr),
        .gnt   (pgnt),
        .idx   (w)
    );

    assign o_gnt      = rstn ? pgnt : '0;
    assign any        = |o_gnt;
    assign o_stk_push = any && i_op[w] == OP_PUSH;
    assign o_stk_pop  = any && i_op[w] == OP_POP;
    assign o_stk_data = any ? i_wdata[w*DATA_W +: DATA_W] : '0;
    assign o_locked   = state == ST_LOCKED;
    assign w_nxt      = w == PW'(NCLI - 1) ? '0 : w + 1'b1;
    assign own_nxt    = owner == PW'(NCLI - 1) ? '0 : owner + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            rr          <= '0;
            owner       <= '0;
            cnt         <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= o_stk_pop ? o_gnt : '0;
            if (o_stk_pop)
                o_rsp_data <= i_stk_data;
            if (state == ST_IDLE) begin
                if (any) begin
                    rr <= w_nxt;
                    if (i_lock[w]) begin
                        state <= ST_LOCKED;
                        owner <= w;
                        cnt   <= '0;
                    end
                end
            end else if (any) begin
                cnt <= '0;
                if (!i_lock[w]) begin
                    state <= ST_IDLE;
                    rr    <= own_nxt;
                end
            end else if (LOCK_TO != 0) begin
                // release happens as the count reaches LOCK_TO, so it never exceeds it
                cnt <= cnt + 1'b1;
                if (cnt == CW'(LOCK_TO - 1)) begin
                    state <= ST_IDLE;
                    rr    <= own_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed checks of grant order, pop responses, locking, timeout and reset
module tb_stack_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;

    logic          clk = 0, rstn = 0;
    logic [N-1:0]  req = '0, op = '0, lock = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]  gnt, rsp_valid;
    logic [DW-1:0] rsp_data, stk_wdata, stk_rdata = '0;
    logic          locked, push, pop, full = 0, empty = 1;
    int            tests = 0, fails = 0;

    stack_arbiter #(.NCLI(N), .DATA_W(DW), .LOCK_TO(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_req       (req),
        .i_op        (op),
        .i_lock      (lock),
        .i_wdata     (wdata),
        .o_gnt       (gnt),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_locked    (locked),
        .o_stk_push  (push),
        .o_stk_pop   (pop),
        .o_stk_data  (stk_wdata),
        .i_stk_data  (stk_rdata),
        .i_stk_full  (full),
        .i_stk_empty (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req = 4'hf;
        tick;
        tick;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_push", push, 0);
        check("rst_locked", locked, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        rstn  = 1;
        wdata = {4'd4, 4'd3, 4'd2, 4'd1};
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t1_gnt", gnt, 32'(1 << (i % 4)));
            check("t1_push", push, 1);
            check("t1_pop", pop, 0);
            check("t1_data", stk_wdata, 32'(i % 4 + 1));
            tick;
        end
        req = '0;
        tick;
        // rr now points at client 2
        empty = 0; stk_rdata = 9; req = 4'b0100; op = 4'b0100;
        #1;
        check("t2_gnt_a", gnt, 4);
        check("t2_pop_a", pop, 1);
        tick;
        stk_rdata = 5;
        #1;
        check("t2_rsp_v_a", rsp_valid, 4);
        check("t2_rsp_d_a", rsp_data, 9);
        check("t2_gnt_b", gnt, 4);
        tick;
        empty = 1; stk_rdata = 0;
        #1;
        check("t2_rsp_v_b", rsp_valid, 4);
        check("t2_rsp_d_b", rsp_data, 5);
        check("t2_gnt_empty", gnt, 0);
        check("t2_pop_empty", pop, 0);
        tick;
        check("t2_rsp_v_off", rsp_valid, 0);
        check("t2_rsp_d_hold", rsp_data, 5);
        full = 1; empty = 0; stk_rdata = 7; req = 4'b0011; op = 4'b0010;
        #1;
        check("t3_gnt_pop", gnt, 2);
        check("t3_pop", pop, 1);
        check("t3_push", push, 0);
        tick;
        check("t3_rsp_v", rsp_valid, 2);
        check("t3_rsp_d", rsp_data, 7);
        full = 0; req = 4'b0001; op = 4'b0000;
        #1;
        check("t3_gnt_push", gnt, 1);
        check("t3_push_b", push, 1);
        tick;
        req = 4'b0100;
        tick;
        // rr now points at client 3
        req = 4'b1111; op = 4'b0000; lock = 4'b1000;
        #1;
        check("t4_gnt_a", gnt, 8);
        check("t4_push_a", push, 1);
        tick;
        check("t4_locked_a", locked, 1);
        op = 4'b1000;
        #1;
        check("t4_gnt_b", gnt, 8);
        check("t4_pop_b", pop, 1);
        tick;
        check("t4_locked_b", locked, 1);
        check("t4_rsp_v", rsp_valid, 8);
        op = 4'b0000; lock = 4'b0000;
        #1;
        check("t4_gnt_c", gnt, 8);
        tick;
        check("t4_locked_c", locked, 0);
        req = 4'b0111;
        #1;
        check("t4_gnt_next", gnt, 1);
        tick;
        req = 4'b0010; lock = 4'b0010;
        #1;
        check("t5_gnt_lock", gnt, 2);
        tick;
        req = 4'b1101; lock = '0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("t5_blocked", gnt, 0);
            check("t5_locked", locked, 1);
            tick;
        end
        check("t5_released", locked, 0);
        check("t5_gnt_after", gnt, 4);
        tick;
        req = 4'b1000; op = 4'b1000; lock = 4'b1000; stk_rdata = 6;
        #1;
        check("t6_gnt_a", gnt, 8);
        tick;
        check("t6_locked", locked, 1);
        #1;
        check("t6_gnt_b", gnt, 8);
        tick;
        check("t6_rsp_pending", rsp_valid, 8);
        rstn = 0;
        #1;
        check("t6_gnt_rst", gnt, 0);
        check("t6_pop_rst", pop, 0);
        tick;
        check("t6_locked_rst", locked, 0);
        check("t6_rsp_v_rst", rsp_valid, 0);
        check("t6_rsp_d_rst", rsp_data, 0);
        rstn = 1; req = 4'b1111; op = '0; lock = '0;
        #1;
        check("t6_rr_rst", gnt, 1);
        tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
